// File: rtl/wb_stage_buf_pkg.sv
// Shared write-back stage definitions: NOP register address, zero word,
// stall-bus width and the per-channel write-back entry layout.
package wb_stage_buf_pkg;

  localparam int STALL_BUS_W = 8;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_DATA_W  = 32;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_DATA_W-1:0] wdata;
  } wb_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_ring_buf.sv
// Generic in-order ring buffer: DEPTH entries of W bits with pointers and count.
// Also presents the entry that will be at the head after this cycle's push/pop.
module wb_ring_buf
  import wb_stage_buf_pkg::*;
#(
  parameter int  W     = 8,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [CNT_W-1:0] count,
  output logic             head_vld_p0,
  output logic [W-1:0]     head_p0
);

  localparam int               PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] remain;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // When entries survive the pop, the next head comes from storage; otherwise
  // the incoming group lands directly on the head with no bubble.
  always_comb begin
    rd_ptr_nxt  = pop ? ptr_inc(rd_ptr) : rd_ptr;
    remain      = count - CNT_W'(pop);
    head_vld_p0 = ~clear & ((remain != '0) | push);
    head_p0     = (remain != '0) ? mem[rd_ptr_nxt] : wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_ptr_nxt;
      count  <= remain + CNT_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wb_stage_buf.sv
// MEM/WB stage register: NCH write-back channels per group through a DEPTH-entry
// in-order buffer with stall, flush and bubble gating. Optional WB_STALL_CNT_EN.
module wb_stage_buf
  import wb_stage_buf_pkg::*;
#(
  parameter int  NCH       = 2,
  parameter int  ADDR_W    = 5,
  parameter int  DATA_W    = 32,
  parameter int  DEPTH     = 2,
  parameter int  STALL_W   = STALL_BUS_W,
  parameter int  STALL_IDX = 7,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*ADDR_W-1:0] mem_wd,
  input  logic [NCH-1:0]        mem_wreg,
  input  logic [NCH*DATA_W-1:0] mem_wdata,
  input  logic                  flush,
  input  logic [STALL_W-1:0]    stall_sign,
  output logic                  wb_valid,
  output logic [NCH*ADDR_W-1:0] wb_wd,
  output logic [NCH-1:0]        wb_wreg,
  output logic [NCH*DATA_W-1:0] wb_wdata,
  output logic [CNT_W-1:0]      count
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int                EW        = ADDR_W + 1 + DATA_W;
  localparam logic [ADDR_W-1:0] NOP_WD    = ADDR_W'(NOP_REG_ADDR);
  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZERO_WORD);

  logic                  stall;
  logic                  pop;
  logic                  push;
  logic [CNT_W-1:0]      count_int;
  logic [NCH*EW-1:0]     grp_p0;
  logic [NCH*EW-1:0]     head_p0;
  logic                  head_vld_p0;
  logic                  unused_stall_bits;

  logic                  vld_p1;
  logic [NCH*ADDR_W-1:0] wd_p1;
  logic [NCH-1:0]        wreg_p1;
  logic [NCH*DATA_W-1:0] wdata_p1;

  // p0: handshake and group packing (in_ready never depends on in_valid)
  assign stall             = stall_sign[STALL_IDX];
  assign unused_stall_bits = ^stall_sign;
  assign pop               = (count_int != '0) & ~stall;
  assign in_ready          = (count_int < CNT_W'(DEPTH)) | pop;
  assign push              = in_valid & in_ready & ~flush;
  assign count             = count_int;

  always_comb begin
    grp_p0 = '0;
    for (int k = 0; k < NCH; k++) begin
      grp_p0[k*EW +: EW] = {mem_wd[k*ADDR_W +: ADDR_W], mem_wreg[k],
                            mem_wdata[k*DATA_W +: DATA_W]};
    end
  end

  wb_ring_buf #(
    .W     (NCH * EW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear       (flush),
    .push        (push),
    .pop         (pop),
    .wr_data     (grp_p0),
    .count       (count_int),
    .head_vld_p0 (head_vld_p0),
    .head_p0     (head_p0)
  );

  // p1: registered head outputs; an empty buffer shows a bubble, not stale data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      wd_p1    <= {NCH{NOP_WD}};
      wreg_p1  <= '0;
      wdata_p1 <= {NCH{ZERO_DATA}};
    end else begin
      vld_p1 <= head_vld_p0;
      for (int k = 0; k < NCH; k++) begin
        if (head_vld_p0) begin
          wd_p1[k*ADDR_W +: ADDR_W]    <= head_p0[k*EW + DATA_W + 1 +: ADDR_W];
          wreg_p1[k]                   <= head_p0[k*EW + DATA_W];
          wdata_p1[k*DATA_W +: DATA_W] <= head_p0[k*EW +: DATA_W];
        end else begin
          wd_p1[k*ADDR_W +: ADDR_W]    <= NOP_WD;
          wreg_p1[k]                   <= 1'b0;
          wdata_p1[k*DATA_W +: DATA_W] <= ZERO_DATA;
        end
      end
    end
  end

  assign wb_valid = vld_p1;
  assign wb_wd    = wd_p1;
  assign wb_wreg  = wreg_p1;
  assign wb_wdata = wdata_p1;

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_p1 <= '0;
    end else if (flush) begin
      stall_cnt_p1 <= '0;
    end else if (stall && vld_p1 && !(&stall_cnt_p1)) begin
      stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: a DEPTH=2/NCH=2 and a DEPTH=3/NCH=1 instance checked
// against queue-based reference models.
module tb_wb_stage_buf;
  import wb_stage_buf_pkg::*;

  typedef wb_entry_t [1:0] grp2_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        in_valid2, in_ready2, flush2, wb_valid2;
  logic [9:0]  mem_wd2, wb_wd2;
  logic [1:0]  mem_wreg2, wb_wreg2, count2;
  logic [63:0] mem_wdata2, wb_wdata2;
  logic [7:0]  stall_sign2;

  logic        in_valid3, in_ready3, flush3, wb_valid3;
  logic [4:0]  mem_wd3, wb_wd3;
  logic [0:0]  mem_wreg3, wb_wreg3;
  logic [1:0]  count3;
  logic [31:0] mem_wdata3, wb_wdata3;
  logic [7:0]  stall_sign3;
`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cycles2, stall_cycles3;
`endif

  grp2_t       q2[$];
  wb_entry_t   q3[$];
  logic [31:0] sc2 = '0;
  logic [31:0] sc3 = '0;

  wb_stage_buf #(.NCH(2), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .mem_wd(mem_wd2), .mem_wreg(mem_wreg2), .mem_wdata(mem_wdata2),
    .flush(flush2), .stall_sign(stall_sign2), .wb_valid(wb_valid2),
    .wb_wd(wb_wd2), .wb_wreg(wb_wreg2), .wb_wdata(wb_wdata2), .count(count2)
`ifdef WB_STALL_CNT_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  wb_stage_buf #(.NCH(1), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .mem_wd(mem_wd3), .mem_wreg(mem_wreg3), .mem_wdata(mem_wdata3),
    .flush(flush3), .stall_sign(stall_sign3), .wb_valid(wb_valid3),
    .wb_wd(wb_wd3), .wb_wreg(wb_wreg3), .wb_wdata(wb_wdata3), .count(count3)
`ifdef WB_STALL_CNT_EN
    , .stall_cycles(stall_cycles3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_entry_t rent();
    wb_entry_t e;
    e.wd    = 5'($urandom);
    e.wreg  = 1'($urandom);
    e.wdata = $urandom;
    return e;
  endfunction

  function automatic grp2_t rgrp2();
    grp2_t g;
    g[0] = rent();
    g[1] = rent();
    return g;
  endfunction

  task automatic check_outs();
    grp2_t     h2;
    wb_entry_t h3;
    h2 = (q2.size() > 0) ? q2[0] : '0;
    h3 = (q3.size() > 0) ? q3[0] : '0;
    chk("wb_valid2", wb_valid2, q2.size() > 0);
    chk("wb_wd2",    wb_wd2,    {h2[1].wd, h2[0].wd});
    chk("wb_wreg2",  wb_wreg2,  {h2[1].wreg, h2[0].wreg});
    chk("wb_wdata2", wb_wdata2, {h2[1].wdata, h2[0].wdata});
    chk("count2",    count2,    q2.size());
    chk("wb_valid3", wb_valid3, q3.size() > 0);
    chk("wb_wd3",    wb_wd3,    h3.wd);
    chk("wb_wreg3",  wb_wreg3,  h3.wreg);
    chk("wb_wdata3", wb_wdata3, h3.wdata);
    chk("count3",    count3,    q3.size());
`ifdef WB_STALL_CNT_EN
    chk("stall_cycles2", stall_cycles2, sc2);
    chk("stall_cycles3", stall_cycles3, sc3);
`endif
  endtask

  task automatic step(input logic v2, input grp2_t g2, input logic fl2, input logic st2,
                      input logic v3, input wb_entry_t e3, input logic fl3, input logic st3);
    logic rdy2, rdy3;
    in_valid2   = v2;
    mem_wd2     = {g2[1].wd, g2[0].wd};
    mem_wreg2   = {g2[1].wreg, g2[0].wreg};
    mem_wdata2  = {g2[1].wdata, g2[0].wdata};
    flush2      = fl2;
    stall_sign2 = {st2, 7'($urandom)};
    in_valid3   = v3;
    mem_wd3     = e3.wd;
    mem_wreg3   = e3.wreg;
    mem_wdata3  = e3.wdata;
    flush3      = fl3;
    stall_sign3 = {st3, 7'($urandom)};
    #1;
    rdy2 = (q2.size() < 2) || (q2.size() > 0 && !st2);
    rdy3 = (q3.size() < 3) || (q3.size() > 0 && !st3);
    chk("in_ready2", in_ready2, rdy2);
    chk("in_ready3", in_ready3, rdy3);
    if (fl2) sc2 = '0;
    else if (st2 && q2.size() > 0 && sc2 != '1) sc2++;
    if (fl3) sc3 = '0;
    else if (st3 && q3.size() > 0 && sc3 != '1) sc3++;
    if (fl2) q2.delete();
    else begin
      if (q2.size() > 0 && !st2) void'(q2.pop_front());
      if (v2 && rdy2) q2.push_back(g2);
    end
    if (fl3) q3.delete();
    else begin
      if (q3.size() > 0 && !st3) void'(q3.pop_front());
      if (v3 && rdy3) q3.push_back(e3);
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic s2(input logic v, input grp2_t g, input logic fl, input logic st);
    step(v, g, fl, st, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic s3(input logic v, input wb_entry_t e, input logic fl, input logic st);
    step(1'b0, '0, 1'b0, 1'b0, v, e, fl, st);
  endtask

  initial begin
    grp2_t a, b, c;
    in_valid2 = 1'b0; mem_wd2 = '0; mem_wreg2 = '0; mem_wdata2 = '0;
    flush2 = 1'b0; stall_sign2 = '0;
    in_valid3 = 1'b0; mem_wd3 = '0; mem_wreg3 = '0; mem_wdata3 = '0;
    flush3 = 1'b0; stall_sign3 = '0;

    #2;
    check_outs();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_outs();

    // single group, then bubbles
    a[0] = '{wd: 5'd5, wreg: 1'b1, wdata: 32'hDEADBEEF};
    a[1] = '0;
    s2(1'b1, a, 1'b0, 1'b0);
    s2(1'b0, '0, 1'b0, 1'b0);
    s2(1'b0, '0, 1'b0, 1'b0);

    // stall fill: C refused, then A, B, C drain back to back
    a = rgrp2();
    b = rgrp2();
    b[1].wd = 5'd0;
    b[1].wreg = 1'b1;
    c = rgrp2();
    s2(1'b1, a, 1'b0, 1'b1);
    s2(1'b1, b, 1'b0, 1'b1);
    s2(1'b1, c, 1'b0, 1'b1);
    s2(1'b1, c, 1'b0, 1'b1);
    s2(1'b1, c, 1'b0, 1'b0);
    s2(1'b0, '0, 1'b0, 1'b0);
    s2(1'b0, '0, 1'b0, 1'b0);

    // full buffer with simultaneous push and pop
    s2(1'b1, rgrp2(), 1'b0, 1'b1);
    s2(1'b1, rgrp2(), 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) s2(1'b1, rgrp2(), 1'b0, 1'b0);

    // flush with concurrent push, and flush over stall
    s2(1'b1, rgrp2(), 1'b1, 1'b0);
    s2(1'b0, '0, 1'b0, 1'b0);
    s2(1'b1, rgrp2(), 1'b0, 1'b1);
    s2(1'b1, rgrp2(), 1'b1, 1'b1);
    s2(1'b0, '0, 1'b0, 1'b0);

    // asynchronous reset mid-traffic
    s2(1'b1, rgrp2(), 1'b0, 1'b1);
    s2(1'b1, rgrp2(), 1'b0, 1'b1);
    in_valid2 = 1'b0;
    stall_sign2 = '0;
    #2 rst = 1'b0;
    q2.delete();
    q3.delete();
    sc2 = '0;
    sc3 = '0;
    #1;
    check_outs();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_outs();

    // random traffic, two channels, depth 2
    for (int i = 0; i < 60; i++)
      s2($urandom_range(0, 3) != 0, rgrp2(), $urandom_range(0, 15) == 0,
         $urandom_range(0, 2) == 0);
    s2(1'b0, '0, 1'b1, 1'b0);

    // depth 3: fill past the wrap, then random stall traffic
    for (int i = 0; i < 4; i++) s3(1'b1, rent(), 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      s3($urandom_range(0, 3) != 0, rent(), $urandom_range(0, 19) == 0,
         $urandom_range(0, 1) == 0);
    for (int i = 0; i < 4; i++) s3(1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
